multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath. Sequences one instruction over 3-5 states.
//  Generates the 3-bit ALUOp consumed by ALU control, plus all datapath mux/enable strobes.
//  Handles memory wait states via mem_ready, with a watchdog against hung accesses.
//  Supported: add, sub, and, or, slt, addi, andi, ori, lw, sw, beq.
// PARAMETERS
//  WDT_CYCLES  255  max cycles waiting on mem_ready in one memory state before abort (1..65535)
// PORTS
//  clk          in   1  clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  opcode       in   6  IR[31:26]; stable from the cycle after IRWrite
//  mem_ready    in   1  memory accepts/completes the current access this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU zero
//  IorD         out  1  0=PC address, 1=ALUOut address
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  instruction register load
//  MemtoReg     out  1  1=MDR to register file, 0=ALUOut
//  RegDst       out  1  1=rd, 0=rt
//  RegWrite     out  1  register file write enable
//  ALUSrcA      out  1  0=PC, 1=A
//  ALUSrcB      out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  ALUOp        out  3  010 add, 011 sub, 000 and, 001 or, 100 use funct
//  PCSource     out  2  00=ALU result, 01=ALUOut
//  instr_done   out  1  1-cycle pulse in the final state of each instruction
//  illegal_op   out  1  1-cycle pulse in DECODE on an unsupported opcode
//  mem_timeout  out  1  sticky; set on watchdog expiry, cleared only by reset
// BEHAVIOUR
//  - Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, andi=001100, ori=001101.
//  - State register is reset asynchronously to START. Outputs are Moore-decoded from state, except
//    PCWrite/IRWrite in FETCH, which are ANDed with mem_ready.
//  - Every output not listed for a state is 0. During reset and in START, all outputs are 0.
//  - START:    one cycle, all outputs 0 -> FETCH.
//  - FETCH:    MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00,
//              IRWrite=PCWrite=mem_ready. Stays until mem_ready=1, then -> DECODE.
//  - DECODE:   ALUSrcA=0, ALUSrcB=11, ALUOp=010. Next state by opcode:
//              lw/sw->MEM_ADDR; R->R_EXEC; beq->BRANCH; addi/andi/ori->I_EXEC;
//              otherwise illegal_op=1 and -> FETCH (no state written).
//  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=010. lw->MEM_RD, sw->MEM_WR.
//  - MEM_RD:   MemRead=1, IorD=1. Waits for mem_ready, then -> MEM_WB.
//  - MEM_WB:   RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 -> FETCH.
//  - MEM_WR:   MemWrite=1, IorD=1. Waits for mem_ready; on mem_ready, instr_done=1 and -> FETCH.
//  - R_EXEC:   ALUSrcA=1, ALUSrcB=00, ALUOp=100 -> R_WB.
//  - R_WB:     RegWrite=1, RegDst=1, MemtoReg=0, ALUOp=100, instr_done=1 -> FETCH.
//  - BRANCH:   ALUSrcA=1, ALUSrcB=00, ALUOp=011, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH.
//  - I_EXEC:   ALUSrcA=1, ALUSrcB=10. ALUOp = 010 for addi, 000 for andi, 001 for ori -> I_WB.
//  - I_WB:     same ALU inputs and ALUOp as I_EXEC; RegWrite=1, RegDst=0, MemtoReg=0,
//              instr_done=1 -> FETCH.
//  - Watchdog:
//    - Counter is cleared on entry to FETCH, MEM_RD or MEM_WR.
//    - It increments each cycle spent in one of these states with mem_ready=0.
//    - When it reaches WDT_CYCLES with mem_ready still 0: set mem_timeout, abandon the access,
//      go to FETCH (from FETCH, restart FETCH with the counter cleared). No PCWrite, IRWrite,
//      RegWrite or instr_done is produced.
//    - If mem_ready=1 in the same cycle the counter hits the limit, the access completes normally.
//  - Counter width is clog2(WDT_CYCLES+1). The counter saturates; it never wraps.
//  - Reset mid-instruction: state -> START immediately. Abandoned writes never complete;
//    mem_timeout clears.
// TESTING
//  - Reset, then lw with mem_ready tied 1: states START,FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB.
//    MemtoReg=RegWrite=1 at cycle 6 after reset release; instr_done is a single pulse.
//  - opcode=000000 (add): R_EXEC and R_WB drive ALUOp=100; R_WB has RegDst=1, RegWrite=1.
//    Total 4 cycles per instruction from FETCH.
//  - beq: BRANCH drives ALUOp=011, PCWriteCond=1, PCSource=01. andi: ALUOp=000; ori: ALUOp=001.
//  - sw with mem_ready low for 3 cycles in MEM_WR: MemWrite held 4 cycles. instr_done only on
//    the mem_ready cycle. No RegWrite anywhere.
//  - WDT_CYCLES=4, mem_ready stuck 0 in MEM_RD: after 4 cycles mem_timeout=1 and -> FETCH with
//    no RegWrite. mem_timeout stays 1 until rst_n low.
//  - opcode=000010: illegal_op pulses in DECODE, next state FETCH. rst_n low during R_EXEC:
//    outputs 0 at once, resume via START.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences each instruction over 3-5 states with a memory-wait watchdog.
module multicycle_control #(
  parameter int unsigned WDT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam int CW = $clog2(WDT_CYCLES + 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_FN  = 3'b100;

  localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);
  localparam logic [CW-1:0] WDT_MAX  = CW'(WDT_CYCLES);

  typedef enum logic [3:0] {
    START,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    R_EXEC,
    R_WB,
    BRANCH,
    I_EXEC,
    I_WB
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic          mem_st;
  logic          wdt_hit;
  logic          is_r, is_lw, is_sw, is_beq;
  logic          is_addi, is_andi, is_ori;
  logic [2:0]    imm_op;

  assign is_r    = (opcode == OP_R);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_addi = (opcode == OP_ADDI);
  assign is_andi = (opcode == OP_ANDI);
  assign is_ori  = (opcode == OP_ORI);

  assign imm_op = is_andi ? ALU_AND :
                  is_ori  ? ALU_OR  : ALU_ADD;

  // Counter holds the number of stalled cycles already spent here,
  // so the last allowed stall is the one seen at WDT_LAST.
  assign mem_st  = state inside {FETCH, MEM_RD, MEM_WR};
  assign wdt_hit = mem_st && !mem_ready && (wcnt == WDT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= START;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      wcnt        <= wcnt_n;
      mem_timeout <= mem_timeout | wdt_hit;
    end
  end

  always_comb begin
    wcnt_n = wcnt;
    if (wdt_hit || (state_n != state)) begin
      wcnt_n = '0;
    end else if (mem_st && !mem_ready && (wcnt != WDT_MAX)) begin
      wcnt_n = wcnt + 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_AND;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state)
      START: begin
        state_n = FETCH;
      end
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        if (mem_ready) state_n = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
        unique case (1'b1)
          is_lw, is_sw:              state_n = MEM_ADDR;
          is_r:                      state_n = R_EXEC;
          is_beq:                    state_n = BRANCH;
          is_addi, is_andi, is_ori:  state_n = I_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_n    = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
        state_n = is_lw ? MEM_RD :
                  is_sw ? MEM_WR : FETCH;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)    state_n = MEM_WB;
        else if (wdt_hit) state_n = FETCH;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_n    = FETCH;
      end
      MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready || wdt_hit) state_n = FETCH;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FN;
        state_n = R_WB;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        ALUOp      = ALU_FN;
        instr_done = 1'b1;
        state_n    = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        state_n     = FETCH;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = imm_op;
        state_n = I_WB;
      end
      I_WB: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = imm_op;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_n    = FETCH;
      end
      default: begin
        state_n = START;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-sequence model plus
// directed scenarios with hand-computed expectations.
module tb_multicycle_control;

  localparam int WDT = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b000010;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       done;
    logic       ill;
    logic       mto;
  } outs_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done, illegal_op, mem_timeout;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 0;
  int cycle_no = 0;

  outs_t act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, instr_done, illegal_op, mem_timeout};

  multicycle_control #(.WDT_CYCLES(WDT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each instruction is a string of step letters.
  // F fetch, D decode, A address, R read, L load-wb, S store,
  // X/Y R-type exec/wb, B branch, I/J immediate exec/wb.
  function automatic string seq_for(input logic [5:0] op);
    case (op)
      OP_LW:                    return "FDARL";
      OP_SW:                    return "FDAS";
      OP_R:                     return "FDXY";
      OP_BEQ:                   return "FDB";
      OP_ADDI, OP_ANDI, OP_ORI: return "FDIJ";
      default:                  return "FD";
    endcase
  endfunction

  function automatic outs_t expect_of(input byte c, input logic [5:0] op,
                                      input logic rdy, input bit mto);
    outs_t o;
    logic [2:0] iop;
    o = '0;
    o.mto = mto;
    iop = (op == OP_ANDI) ? 3'b000 : (op == OP_ORI) ? 3'b001 : 3'b010;
    case (c)
      "F": begin
        o.mrd = 1; o.srcb = 2'b01; o.aluop = 3'b010;
        o.pcw = rdy; o.irw = rdy;
      end
      "D": begin
        o.srcb = 2'b11; o.aluop = 3'b010;
        o.ill = (seq_for(op).len() == 2);
      end
      "A": begin o.srca = 1; o.srcb = 2'b10; o.aluop = 3'b010; end
      "R": begin o.mrd = 1; o.iord = 1; end
      "L": begin o.rw = 1; o.m2r = 1; o.done = 1; end
      "S": begin o.mwr = 1; o.iord = 1; o.done = rdy; end
      "X": begin o.srca = 1; o.aluop = 3'b100; end
      "Y": begin o.rw = 1; o.rdst = 1; o.aluop = 3'b100; o.done = 1; end
      "B": begin
        o.srca = 1; o.aluop = 3'b011; o.pcwc = 1;
        o.pcsrc = 2'b01; o.done = 1;
      end
      "I": begin o.srca = 1; o.srcb = 2'b10; o.aluop = iop; end
      "J": begin
        o.srca = 1; o.srcb = 2'b10; o.aluop = iop;
        o.rw = 1; o.done = 1;
      end
      default: o.mto = 0;
    endcase
    return o;
  endfunction

  bit    m_zst = 1;
  string m_seq = "FD";
  int    m_pos = 0;
  int    m_wait = 0;
  bit    m_mto = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        m_zst = 1; m_mto = 0; m_seq = "FD"; m_pos = 0; m_wait = 0;
      end else if (m_zst) begin
        m_zst = 0; m_seq = "FD"; m_pos = 0; m_wait = 0;
      end else begin
        automatic byte c = m_seq[m_pos];
        if (c == "D") m_seq = seq_for(opcode);
        if ((c == "F" || c == "R" || c == "S") && !mem_ready) begin
          m_wait++;
          if (m_wait == WDT) begin
            m_mto = 1; m_seq = "FD"; m_pos = 0; m_wait = 0;
          end
        end else begin
          m_wait = 0;
          m_pos++;
          if (m_pos >= m_seq.len()) begin
            m_pos = 0; m_seq = "FD";
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      automatic byte   c = m_zst ? "Z" : m_seq[m_pos];
      automatic outs_t e = expect_of(c, opcode, mem_ready, m_mto);
      cycle_no++;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL model cyc=%0d step=%s got=%05h exp=%05h",
                 cycle_no, c, act, e);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Starts anywhere in a FETCH cycle; one pattern char per cycle.
  task automatic run_pat(input logic [5:0] op, input string pat);
    opcode = op;
    for (int i = 0; i < pat.len(); i++) begin
      mem_ready = (pat[i] == "1");
      cyc();
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_LW;
    repeat (2) @(posedge clk);
    run_cmp = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    mid(); lit("start_zero", 32'(act), 0);
    cyc(); cyc(); cyc(); cyc();
    mid(); lit("lw_rd", {MemRead, IorD, instr_done}, 3'b110);
    cyc();
    mid(); lit("lw_wb_c6", {MemtoReg, RegWrite, RegDst, instr_done}, 4'b1101);
    cyc();
    mid(); lit("lw_done_pulse", {instr_done, MemRead}, 2'b01);

    opcode = OP_R;
    cyc(); cyc();
    mid(); lit("add_exec", {ALUSrcA, ALUSrcB, ALUOp}, 6'b1_00_100);
    cyc();
    mid(); lit("add_wb", {RegDst, RegWrite, MemtoReg, ALUOp, instr_done}, 7'b110_100_1);
    cyc();
    mid(); lit("add_4cyc", {MemRead, IorD, ALUSrcA, ALUSrcB}, 5'b10001);

    opcode = OP_BEQ;
    cyc(); cyc();
    mid(); lit("beq", {ALUOp, PCWriteCond, PCSource, instr_done}, 7'b011_1_01_1);
    cyc();

    opcode = OP_ANDI;
    cyc(); cyc();
    mid(); lit("andi_exec", {ALUOp, ALUSrcB}, 5'b000_10);
    cyc();
    mid(); lit("andi_wb", {ALUOp, RegWrite, instr_done}, 5'b000_1_1);
    cyc();

    opcode = OP_ORI;
    cyc(); cyc();
    mid(); lit("ori_exec", ALUOp, 3'b001);
    cyc(); cyc();

    run_pat(OP_ADDI, "1111");
    run_pat(OP_LW, "0011111");

    opcode = OP_SW;
    cyc(); cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      mid();
      lit("sw_memwrite", {MemWrite, RegWrite}, 2'b10);
      lit("sw_done", instr_done, 32'(i == 3));
      cyc();
    end
    mem_ready = 1'b1;
    mid(); lit("sw_after", {MemWrite, MemRead}, 2'b01);

    run_pat(OP_LW, "11100011");
    mid(); lit("lw_limit_ok", mem_timeout, 0);

    opcode = OP_LW;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0;
    for (int i = 0; i < WDT; i++) begin
      mid();
      lit("wdt_wait", {MemRead, IorD, mem_timeout, RegWrite}, 4'b1100);
      cyc();
    end
    mid(); lit("wdt_abort", {MemRead, IorD, mem_timeout, RegWrite}, 4'b1010);
    mem_ready = 1'b1;
    cyc();

    run_pat(OP_ADDI, "00001111");
    run_pat(OP_SW, "1110000");

    opcode = OP_BAD;
    cyc();
    mid(); lit("illegal", {illegal_op, RegWrite, instr_done}, 3'b100);
    cyc();
    mid(); lit("illegal_next", {illegal_op, MemRead}, 2'b01);
    run_pat(OP_SW, "1111");

    opcode = OP_R;
    cyc(); cyc();
    lit("mto_sticky", mem_timeout, 1);
    #2 rst_n = 1'b0;
    #1 lit("rst_async", 32'(act), 0);
    cyc();
    rst_n = 1'b1;
    mid(); lit("rst_start", 32'(act), 0);
    cyc();
    mid(); lit("rst_fetch", {MemRead, mem_timeout}, 2'b10);
    run_pat(OP_R, "1111");
    run_pat(OP_BEQ, "111");
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
